// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the single-outstanding Wishbone initiator.
package wb_initiator_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_STB_W = 4;
  localparam int TIMER_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Bounded wait counter: flags the last permitted wait cycle while enabled.
module wb_timeout_counter
  import wb_initiator_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [TIMER_W-1:0] i_limit,
  output logic               o_expire
);

  logic [TIMER_W-1:0] r_count;
  logic               w_at_last;

  assign w_at_last = (r_count == (i_limit - TIMER_W'(1)));
  assign o_expire  = i_enable && w_at_last;

  // Holding at limit-1 keeps the count from ever wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_last) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic-cycle initiator: one request in flight, bounded ACK wait,
// read data or timeout error returned on a valid/ready response channel.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int                  ADDR_WIDTH     = 17,
  parameter int                  TIMEOUT_CYCLES = 255,
  parameter logic [WB_DAT_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  WB_CLK_i,
  input  logic                  WB_RSTn_i,
  input  logic                  REQ_VALID_i,
  output logic                  REQ_READY_o,
  input  logic [ADDR_WIDTH-1:0] REQ_ADR_i,
  input  logic                  REQ_WE_i,
  input  logic [WB_STB_W-1:0]   REQ_BYTE_STB_i,
  input  logic [WB_DAT_W-1:0]   REQ_DAT_i,
  output logic                  RSP_VALID_o,
  input  logic                  RSP_READY_i,
  output logic [WB_DAT_W-1:0]   RSP_DAT_o,
  output logic                  RSP_ERR_o,
  output logic [ADDR_WIDTH-1:0] WBm_ADR_o,
  output logic                  WBm_CYC_o,
  output logic                  WBm_STB_o,
  output logic                  WBm_WE_o,
  output logic [WB_STB_W-1:0]   WBm_BYTE_STB_o,
  output logic [WB_DAT_W-1:0]   WBm_DAT_o,
  input  logic [WB_DAT_W-1:0]   WBm_DAT_i,
  input  logic                  WBm_ACK_i
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYCLES);

  state_t r_state;
  logic   w_accept;
  logic   w_in_bus;
  logic   w_expire;

  assign REQ_READY_o = (r_state == ST_IDLE);
  assign w_accept    = REQ_READY_o && REQ_VALID_i;
  assign w_in_bus    = (r_state == ST_BUS);

  wb_timeout_counter u_timeout (
    .i_clk    (WB_CLK_i),
    .i_rst_n  (WB_RSTn_i),
    .i_clear  (w_accept),
    .i_enable (w_in_bus),
    .i_limit  (LIMIT),
    .o_expire (w_expire)
  );

  always_ff @(posedge WB_CLK_i or negedge WB_RSTn_i) begin
    if (!WB_RSTn_i) begin
      r_state        <= ST_IDLE;
      WBm_CYC_o      <= 1'b0;
      WBm_STB_o      <= 1'b0;
      WBm_WE_o       <= 1'b0;
      WBm_ADR_o      <= '0;
      WBm_BYTE_STB_o <= '0;
      WBm_DAT_o      <= '0;
      RSP_VALID_o    <= 1'b0;
      RSP_ERR_o      <= 1'b0;
      RSP_DAT_o      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            WBm_ADR_o      <= REQ_ADR_i;
            WBm_WE_o       <= REQ_WE_i;
            WBm_BYTE_STB_o <= REQ_BYTE_STB_i;
            WBm_DAT_o      <= REQ_DAT_i;
            WBm_CYC_o      <= 1'b1;
            WBm_STB_o      <= 1'b1;
            r_state        <= ST_BUS;
          end
        end
        ST_BUS: begin
          // ACK takes priority so a reply in the last wait cycle still succeeds.
          if (WBm_ACK_i) begin
            WBm_CYC_o   <= 1'b0;
            WBm_STB_o   <= 1'b0;
            RSP_VALID_o <= 1'b1;
            RSP_ERR_o   <= 1'b0;
            RSP_DAT_o   <= WBm_WE_o ? '0 : WBm_DAT_i;
            r_state     <= ST_RESP;
          end else if (w_expire) begin
            WBm_CYC_o   <= 1'b0;
            WBm_STB_o   <= 1'b0;
            RSP_VALID_o <= 1'b1;
            RSP_ERR_o   <= 1'b1;
            RSP_DAT_o   <= TIMEOUT_DATA;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (RSP_READY_i) begin
            RSP_VALID_o <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator against a small GPIO-style register responder.
module tb_wb_initiator;
  import wb_initiator_pkg::*;

  localparam int AW = 17;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_adr;
  logic          req_we;
  logic [3:0]    req_stb;
  logic [31:0]   req_dat;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_dat;
  logic          rsp_err;
  logic [AW-1:0] wb_adr;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [3:0]    wb_sel;
  logic [31:0]   wb_dat_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack;

  always #5 clk = ~clk;

  wb_initiator #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_DATA   (32'hDEAD_BEEF)
  ) dut (
    .WB_CLK_i       (clk),
    .WB_RSTn_i      (rst_n),
    .REQ_VALID_i    (req_valid),
    .REQ_READY_o    (req_ready),
    .REQ_ADR_i      (req_adr),
    .REQ_WE_i       (req_we),
    .REQ_BYTE_STB_i (req_stb),
    .REQ_DAT_i      (req_dat),
    .RSP_VALID_o    (rsp_valid),
    .RSP_READY_i    (rsp_ready),
    .RSP_DAT_o      (rsp_dat),
    .RSP_ERR_o      (rsp_err),
    .WBm_ADR_o      (wb_adr),
    .WBm_CYC_o      (wb_cyc),
    .WBm_STB_o      (wb_stb),
    .WBm_WE_o       (wb_we),
    .WBm_BYTE_STB_o (wb_sel),
    .WBm_DAT_o      (wb_dat_o),
    .WBm_DAT_i      (wb_dat_i),
    .WBm_ACK_i      (wb_ack)
  );

  // Responder: 4 registers at 0x1000, ACK registered ack_delay cycles after STB.
  logic        ack_en;
  int          ack_delay;
  int          wcnt;
  logic [31:0] mem [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wcnt     <= 0;
      wb_dat_i <= 32'd0;
      for (int k = 0; k < 4; k++) mem[k] <= 32'd0;
    end else if (wb_cyc && wb_stb && !wb_ack) begin
      if (ack_en && wcnt == ack_delay) begin
        wb_ack <= 1'b1;
        wcnt   <= 0;
        if (wb_adr[16:4] == 13'h100) begin
          if (wb_we) begin
            for (int b = 0; b < 4; b++)
              if (wb_sel[b]) mem[wb_adr[3:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
          end else begin
            wb_dat_i <= mem[wb_adr[3:2]];
          end
        end else begin
          wb_dat_i <= 32'd0;
        end
      end else begin
        wb_ack <= 1'b0;
        wcnt   <= wcnt + 1;
      end
    end else begin
      wb_ack <= 1'b0;
      wcnt   <= 0;
    end
  end

  int   cyc_cnt = 0;
  int   cyc_hi = 0;
  int   cyc_rise = 0;
  int   rsp_seen = 0;
  logic cyc_prev = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) begin
    cyc_prev <= wb_cyc;
    if (wb_cyc) cyc_hi <= cyc_hi + 1;
    if (wb_cyc && !cyc_prev) cyc_rise <= cyc_rise + 1;
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
  end

  int checks = 0;
  int errors = 0;
  int acc_edge = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [AW-1:0] adr, input logic we, input logic [3:0] stb,
                      input logic [31:0] dat);
    logic ok;
    req_adr   = adr;
    req_we    = we;
    req_stb   = stb;
    req_dat   = dat;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_accepted", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    acc_edge  = cyc_cnt;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic e, output int lat);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("rsp_arrived", 32'(ok), 32'd1);
    d   = rsp_dat;
    e   = rsp_err;
    lat = cyc_cnt - acc_edge;
  endtask

  task automatic txn(input string tag, input logic [AW-1:0] adr, input logic we,
                     input logic [3:0] stb, input logic [31:0] dat,
                     input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    logic [31:0] d;
    logic        e;
    int          lat;
    send(adr, we, stb, dat);
    wait_rsp(d, e, lat);
    check({tag, "_dat"}, d, exp_d);
    check({tag, "_err"}, 32'(e), 32'(exp_e));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    $display("TXN %s adr=%h we=%0d stb=%h dat=%h -> rsp=%h err=%0d lat=%0d",
             tag, adr, we, stb, dat, d, e, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          h0;
    int          r0;
    int          s0;

    req_valid = 1'b0;
    req_adr   = '0;
    req_we    = 1'b0;
    req_stb   = 4'h0;
    req_dat   = 32'd0;
    rsp_ready = 1'b1;
    ack_en    = 1'b1;
    ack_delay = 0;

    #1;
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_adr", 32'(wb_adr), 32'd0);
    check("rst_sel", 32'(wb_sel), 32'd0);
    check("rst_wdat", wb_dat_o, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    txn("wr_full", 17'h1004, 1'b1, 4'hF, 32'hA5A5_0F0F, 32'd0, 1'b0, 2);
    txn("rd_full", 17'h1004, 1'b0, 4'hF, 32'd0, 32'hA5A5_0F0F, 1'b0, 2);
    txn("wr_part", 17'h1004, 1'b1, 4'h2, 32'h0000_3C00, 32'd0, 1'b0, 2);
    txn("rd_part", 17'h1004, 1'b0, 4'hF, 32'd0, 32'hA5A5_3C0F, 1'b0, 2);

    ack_en = 1'b0;
    h0 = cyc_hi;
    txn("timeout", 17'h1004, 1'b0, 4'hF, 32'd0, 32'hDEAD_BEEF, 1'b1, TO);
    check("timeout_cyc_len", 32'(cyc_hi - h0), 32'(TO));
    txn("timeout_wr", 17'h1008, 1'b1, 4'hF, 32'h1111_2222, 32'hDEAD_BEEF, 1'b1, TO);

    ack_en    = 1'b1;
    ack_delay = TO - 2;
    txn("ack_last", 17'h1004, 1'b0, 4'hF, 32'd0, 32'hA5A5_3C0F, 1'b0, TO);
    ack_delay = TO - 1;
    txn("ack_late", 17'h1004, 1'b0, 4'hF, 32'd0, 32'hDEAD_BEEF, 1'b1, TO);
    ack_delay = 0;

    rsp_ready = 1'b0;
    send(17'h1004, 1'b0, 4'hF, 32'd0);
    wait_rsp(d, e, lat);
    check("bp_first_dat", d, 32'hA5A5_3C0F);
    req_adr   = 17'h1008;
    req_we    = 1'b1;
    req_stb   = 4'hF;
    req_dat   = 32'h1234_5678;
    req_valid = 1'b1;
    r0 = cyc_rise;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_dat", rsp_dat, 32'hA5A5_3C0F);
      check("bp_rsp_err", 32'(rsp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_cyc", 32'(wb_cyc), 32'd0);
    end
    check("bp_no_new_cyc", 32'(cyc_rise - r0), 32'd0);
    $display("TXN bp_hold rd adr=01004 rsp=%h held 10 cycles", d);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_ready", 32'(req_ready), 32'd1);
    check("bp_release_cyc", 32'(wb_cyc), 32'd0);
    @(posedge clk);
    #1;
    acc_edge  = cyc_cnt;
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_second_cyc", 32'(wb_cyc), 32'd1);
    check("bp_second_adr", 32'(wb_adr), 32'h1008);
    check("bp_second_we", 32'(wb_we), 32'd1);
    wait_rsp(d, e, lat);
    check("bp_second_err", 32'(e), 32'd0);
    check("bp_second_lat", 32'(lat), 32'd2);
    $display("TXN bp_second wr adr=01008 dat=12345678 -> err=%0d lat=%0d", e, lat);
    @(posedge clk);
    #1;
    txn("rd_after_bp", 17'h1008, 1'b0, 4'hF, 32'd0, 32'h1234_5678, 1'b0, 2);

    ack_en = 1'b0;
    send(17'h1004, 1'b0, 4'hF, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    check("mid_bus_cyc", 32'(wb_cyc), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_cyc", 32'(wb_cyc), 32'd0);
    check("arst_stb", 32'(wb_stb), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_adr", 32'(wb_adr), 32'd0);
    $display("TXN reset_mid_bus cyc=%0d stb=%0d rsp_valid=%0d", wb_cyc, wb_stb, rsp_valid);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ack_en = 1'b1;
    s0 = rsp_seen;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_rsp", 32'(rsp_seen - s0), 32'd0);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_cyc", 32'(wb_cyc), 32'd0);
    @(posedge clk);
    #1;
    txn("wr_post_rst", 17'h1000, 1'b1, 4'hF, 32'h0BAD_F00D, 32'd0, 1'b0, 2);
    txn("rd_post_rst", 17'h1000, 1'b0, 4'hF, 32'd0, 32'h0BAD_F00D, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
